// File: rtl/mem_access_ctrl_if.sv
// EX/MEM-stage memory port bundle: pipeline control, scratchpad port and shared-bus port.
// master = access controller, slave = pipeline/memory side.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 32
);
    localparam int OFS_W   = $clog2(DATA_W/8);
    localparam int WADDR_W = DATA_W - OFS_W;
    localparam int BE_W    = DATA_W/8;

    logic               stall;
    logic               flush;
    logic               busy;
    logic               ex_en;
    logic [3:0]         ex_mem_op;
    logic [DATA_W-1:0]  ex_mem_wr_data;
    logic [DATA_W-1:0]  ex_out;
    logic [DATA_W-1:0]  out;
    logic               miss_align;

    logic [DATA_W-1:0]  spm_rd_data;
    logic [WADDR_W-1:0] spm_addr;
    logic               spm_as_;
    logic               spm_rw;
    logic [DATA_W-1:0]  spm_wr_data;
    logic [BE_W-1:0]    spm_be;

    logic [DATA_W-1:0]  bus_rd_data;
    logic               bus_rdy_;
    logic               bus_grnt_;
    logic               bus_req_;
    logic [WADDR_W-1:0] bus_addr;
    logic               bus_as_;
    logic               bus_rw;
    logic [DATA_W-1:0]  bus_wr_data;
    logic [BE_W-1:0]    bus_be;

    modport master (
        input  stall, flush, ex_en, ex_mem_op, ex_mem_wr_data, ex_out,
               spm_rd_data, bus_rd_data, bus_rdy_, bus_grnt_,
        output busy, out, miss_align,
               spm_addr, spm_as_, spm_rw, spm_wr_data, spm_be,
               bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data, bus_be
    );

    modport slave (
        output stall, flush, ex_en, ex_mem_op, ex_mem_wr_data, ex_out,
               spm_rd_data, bus_rd_data, bus_rdy_, bus_grnt_,
        input  busy, out, miss_align,
               spm_addr, spm_as_, spm_rw, spm_wr_data, spm_be,
               bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data, bus_be
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: zero-wait scratchpad plus request/grant/ready bus FSM.
// Define MEM_SUBWORD_EN to enable halfword/byte loads and stores (lane select, sign extension).
module mem_access_ctrl #(
    parameter int         DATA_W  = 32,
    parameter logic [1:0] SPM_TAG = 2'b00
) (
    input logic              clk,
    input logic              reset,
    mem_access_ctrl_if.master mif
);
    localparam int OFS_W = $clog2(DATA_W/8);
    localparam int BE_W  = DATA_W/8;

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, HOLD} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_rd_buf;

    logic [OFS_W-1:0]    w_ofs;
    logic                w_is_load, w_is_store, w_mis, w_acc, w_spm;
    logic                w_bus_req_n, w_bus_as_n, w_busy, w_latch;
    logic [BE_W-1:0]     w_be;
    logic [DATA_W-1:0]   w_wr_data, w_spm_ld, w_bus_ld, w_out;

    assign w_ofs      = mif.ex_out[OFS_W-1:0];
    assign w_is_load  = mif.ex_en && (mif.ex_mem_op >= OP_LW) && (mif.ex_mem_op <= OP_LBU);
    assign w_is_store = mif.ex_en && (mif.ex_mem_op >= OP_SW) && (mif.ex_mem_op <= OP_SB);

    always_comb begin
        w_mis = 1'b0;
        if (mif.ex_en) begin
            case (mif.ex_mem_op)
                OP_LW, OP_SW: w_mis = (w_ofs != '0);
`ifdef MEM_SUBWORD_EN
                OP_LH, OP_LHU, OP_SH: w_mis = w_ofs[0];
`else
                OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SH, OP_SB: w_mis = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign w_acc = (w_is_load || w_is_store) && !w_mis;
    assign w_spm = (mif.ex_out[DATA_W-1 -: 2] == SPM_TAG);

`ifdef MEM_SUBWORD_EN
    function automatic logic [DATA_W-1:0] f_load(input logic [DATA_W-1:0] d,
                                                 input logic [3:0] op,
                                                 input logic [OFS_W-1:0] ofs);
        logic [DATA_W-1:0] sh;
        sh = d >> {ofs, 3'b000};
        case (op)
            OP_LH:   return {{(DATA_W-16){sh[15]}}, sh[15:0]};
            OP_LHU:  return {{(DATA_W-16){1'b0}},   sh[15:0]};
            OP_LB:   return {{(DATA_W-8){sh[7]}},   sh[7:0]};
            OP_LBU:  return {{(DATA_W-8){1'b0}},    sh[7:0]};
            default: return d;
        endcase
    endfunction

    assign w_spm_ld = f_load(mif.spm_rd_data, mif.ex_mem_op, w_ofs);
    assign w_bus_ld = f_load(mif.bus_rd_data, mif.ex_mem_op, w_ofs);

    // Store data is replicated into every lane; byte enables pick the addressed one(s).
    always_comb begin
        w_be      = '1;
        w_wr_data = mif.ex_mem_wr_data;
        case (mif.ex_mem_op)
            OP_SH: begin
                w_be      = BE_W'(2'b11) << w_ofs;
                w_wr_data = {(DATA_W/16){mif.ex_mem_wr_data[15:0]}};
            end
            OP_SB: begin
                w_be      = BE_W'(1'b1) << w_ofs;
                w_wr_data = {BE_W{mif.ex_mem_wr_data[7:0]}};
            end
            default: ;
        endcase
    end
`else
    assign w_spm_ld  = mif.spm_rd_data;
    assign w_bus_ld  = mif.bus_rd_data;
    assign w_be      = '1;
    assign w_wr_data = mif.ex_mem_wr_data;
`endif

    always_comb begin
        w_next      = r_state;
        w_bus_req_n = 1'b1;
        w_bus_as_n  = 1'b1;
        w_busy      = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: if (w_acc && !w_spm) begin
                w_bus_req_n = 1'b0;
                w_busy      = 1'b1;
                w_next      = REQ;
            end
            REQ: begin
                w_bus_req_n = 1'b0;
                w_busy      = 1'b1;
                if (!mif.bus_grnt_) begin
                    w_bus_as_n = 1'b0;
                    w_next     = ACCESS;
                end
            end
            ACCESS: begin
                w_bus_req_n = 1'b0;
                w_busy      = mif.bus_rdy_;
                if (!mif.bus_rdy_) begin
                    w_latch = 1'b1;
                    w_next  = mif.stall ? HOLD : IDLE;
                end
            end
            HOLD: begin
                w_bus_req_n = 1'b0;
                if (!mif.stall) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Flush and reset both drop the transfer and anything it returned.
        if (mif.flush || !reset) begin
            w_next      = IDLE;
            w_bus_req_n = 1'b1;
            w_bus_as_n  = 1'b1;
            w_busy      = 1'b0;
            w_latch     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_rd_buf <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) r_rd_buf <= w_is_load ? w_bus_ld : '0;
        end
    end

    always_comb begin
        w_out = mif.ex_out;
        if (r_state == HOLD && !mif.flush) w_out = r_rd_buf;
        else if (w_mis)                    w_out = '0;
        else if (w_acc) begin
            if (w_is_store)   w_out = '0;
            else if (w_spm)   w_out = w_spm_ld;
            else if (w_latch) w_out = w_bus_ld;
            else              w_out = '0;
        end
    end

    assign mif.out         = w_out;
    assign mif.miss_align  = w_mis;
    assign mif.busy        = w_busy;

    assign mif.spm_addr    = mif.ex_out[DATA_W-1:OFS_W];
    assign mif.spm_as_     = !(reset && w_acc && w_spm);
    assign mif.spm_rw      = w_is_load;
    assign mif.spm_wr_data = w_wr_data;
    assign mif.spm_be      = w_be;

    assign mif.bus_req_    = w_bus_req_n;
    assign mif.bus_addr    = mif.ex_out[DATA_W-1:OFS_W];
    assign mif.bus_as_     = w_bus_as_n;
    assign mif.bus_rw      = w_is_load;
    assign mif.bus_wr_data = w_wr_data;
    assign mif.bus_be      = w_be;
endmodule
